// File: rtl/credit_tracker_pkg.sv
// Shared types and state encodings for the credit tracker.
// Contents:
//   credit_state_t  2-bit FSM state type
//   CR_*            state encodings (INIT, ACTIVE, DRAIN, DRAINED)
package credit_tracker_pkg;

    typedef logic [1:0] credit_state_t;

    localparam credit_state_t CR_INIT    = 2'd0;
    localparam credit_state_t CR_ACTIVE  = 2'd1;
    localparam credit_state_t CR_DRAIN   = 2'd2;
    localparam credit_state_t CR_DRAINED = 2'd3;

endpackage

// File: rtl/credit_tracker_if.sv
// Link-side signal bundle for the credit tracker.
// Modports:
//   master  issuing side: drives remote_ready, send_valid, ret_valid, ret_cnt, drain_req
//   slave   tracker side: drives send_ready, drained, credits, no_credits, almost_out,
//           overflow_err
interface credit_tracker_if #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_RETURN = 2
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = $clog2(MAX_RETURN + 1);

    logic          remote_ready;
    logic          send_valid;
    logic          send_ready;
    logic          ret_valid;
    logic [RW-1:0] ret_cnt;
    logic          drain_req;
    logic          drained;
    logic [CW-1:0] credits;
    logic          no_credits;
    logic          almost_out;
    logic          overflow_err;

    modport master (
        output remote_ready, send_valid, ret_valid, ret_cnt, drain_req,
        input  send_ready, drained, credits, no_credits, almost_out, overflow_err
    );

    modport slave (
        input  remote_ready, send_valid, ret_valid, ret_cnt, drain_req,
        output send_ready, drained, credits, no_credits, almost_out, overflow_err
    );

endinterface

// File: rtl/credit_counter.sv
// Saturating credit counter.
// Ports:
//   clk, rst    clock, async active-low reset
//   dec         consume one credit this cycle
//   add         credits returned this cycle (already gated and clamped)
//   clear       force count to 0 (highest priority)
//   load        force count to DEPTH
//   count       registered credit count
//   count_next  value count takes on the next edge
//   overflow    pulse: the net update exceeded DEPTH and was saturated
module credit_counter #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_RETURN = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             dec,
    input  logic [$clog2(MAX_RETURN+1)-1:0]  add,
    input  logic                             clear,
    input  logic                             load,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [$clog2(DEPTH+1)-1:0]       count_next,
    output logic                             overflow
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [CW:0]   FULL_W = (CW + 1)'(DEPTH);

    logic [CW-1:0] count_q;
    logic [CW:0]   sum;

    // One extra bit so an over-return is visible instead of wrapping.
    always_comb begin
        sum        = (CW + 1)'(count_q) + (CW + 1)'(add) - (CW + 1)'(dec);
        overflow   = 1'b0;
        count_next = sum[CW-1:0];
        if (clear) begin
            count_next = '0;
        end else if (load) begin
            count_next = FULL;
        end else if (sum > FULL_W) begin
            overflow   = 1'b1;
            count_next = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_next;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/credit_tracker.sv
// Producer-side credit tracker for a credit-based link into a DEPTH-entry remote buffer.
// Ports:
//   clk  clock
//   rst  async active-low reset
//   bus  credit_tracker_if.slave: send handshake, credit returns, drain handshake, status
module credit_tracker
    import credit_tracker_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned MAX_RETURN = 2
) (
    input  logic             clk,
    input  logic             rst,
    credit_tracker_if.slave  bus
);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned RW = $clog2(MAX_RETURN + 1);

    localparam logic [CW-1:0] FULL  = CW'(DEPTH);
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETURN);

    credit_state_t state_q, state_d;
    logic          overflow_err_q, overflow_err_d;

    logic [CW-1:0] count, count_next;
    logic [RW-1:0] ret_amt;
    logic          cnt_overflow;
    logic          send_ready, fire;
    logic          ret_too_big, ret_in_init;
    logic          clear, load, full_next;

    // Registered-only: no path from send_valid or ret_* to send_ready.
    assign send_ready = (state_q == CR_ACTIVE) && (count != '0);
    assign fire       = bus.send_valid & send_ready;

    always_comb begin
        ret_too_big = bus.ret_valid && (bus.ret_cnt > MAX_R);
        ret_in_init = bus.ret_valid && (state_q == CR_INIT);
        ret_amt     = '0;
        if (bus.ret_valid && (state_q != CR_INIT)) begin
            ret_amt = ret_too_big ? MAX_R : bus.ret_cnt;
        end
        clear = (state_q != CR_INIT) && !bus.remote_ready;
        load  = (state_q == CR_INIT) && bus.remote_ready;
    end

    credit_counter #(
        .DEPTH      (DEPTH),
        .MAX_RETURN (MAX_RETURN)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .dec        (fire),
        .add        (ret_amt),
        .clear      (clear),
        .load       (load),
        .count      (count),
        .count_next (count_next),
        .overflow   (cnt_overflow)
    );

    assign full_next = (count_next == FULL);

    always_comb begin
        state_d = state_q;
        case (state_q)
            CR_INIT:    if (bus.remote_ready) state_d = CR_ACTIVE;
            // Enter DRAIN, or pass straight to DRAINED if every credit is already home.
            CR_ACTIVE:  if (bus.drain_req) state_d = full_next ? CR_DRAINED : CR_DRAIN;
            CR_DRAIN:   if (full_next) state_d = CR_DRAINED;
            CR_DRAINED: if (!bus.drain_req) state_d = CR_ACTIVE;
            default:    state_d = CR_INIT;
        endcase
        // Remote side went away: drop everything and wait for it to come back.
        if (clear) state_d = CR_INIT;
    end

    assign overflow_err_d = overflow_err_q | cnt_overflow | ret_too_big | ret_in_init;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= CR_INIT;
            overflow_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            overflow_err_q <= overflow_err_d;
        end
    end

    assign bus.send_ready   = send_ready;
    assign bus.drained      = (state_q == CR_DRAINED);
    assign bus.credits      = count;
    assign bus.no_credits   = (count == '0);
    assign bus.almost_out   = (count == CW'(1));
    assign bus.overflow_err = overflow_err_q;

`ifndef SYNTHESIS
    a_no_fire_empty: assert property (@(posedge clk) disable iff (!rst)
        !(fire && (count == '0)));
    a_no_ret_in_init: assert property (@(posedge clk) disable iff (!rst)
        !(bus.ret_valid && (state_q == CR_INIT)));
`endif

endmodule

// File: tb/tb_credit_tracker.sv
module tb_credit_tracker;
    localparam int DEPTH = 4;
    localparam int MAXR  = 2;

    localparam int M_INIT    = 0;
    localparam int M_ACTIVE  = 1;
    localparam int M_DRAIN   = 2;
    localparam int M_DRAINED = 3;

    logic clk;
    logic rst;

    credit_tracker_if #(.DEPTH(DEPTH), .MAX_RETURN(MAXR)) bus ();

    credit_tracker #(.DEPTH(DEPTH), .MAX_RETURN(MAXR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural reference: mode, credits held, sticky error.
    int m_mode = M_INIT;
    int m_cred = 0;
    int m_err  = 0;

    typedef struct {
        logic       rr;
        logic       sv;
        logic       rv;
        logic [1:0] rc;
        logic       dr;
        int         ec;
        int         esr;
        int         edr;
        int         eerr;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic rr, input logic sv, input logic rv, input logic [1:0] rc,
                           input logic dr, input int ec, input int esr, input int edr,
                           input int eerr);
        vec_t v;
        v.rr = rr; v.sv = sv; v.rv = rv; v.rc = rc; v.dr = dr;
        v.ec = ec; v.esr = esr; v.edr = edr; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ec, input int esr, input int edr,
                           input int eerr);
        chk({tag, " credits"}, 32'(bus.credits), ec);
        chk({tag, " send_ready"}, 32'(bus.send_ready), esr);
        chk({tag, " drained"}, 32'(bus.drained), edr);
        chk({tag, " overflow_err"}, 32'(bus.overflow_err), eerr);
        chk({tag, " no_credits"}, 32'(bus.no_credits), (ec == 0) ? 1 : 0);
        chk({tag, " almost_out"}, 32'(bus.almost_out), (ec == 1) ? 1 : 0);
    endtask

    task automatic model_reset();
        m_mode = M_INIT;
        m_cred = 0;
        m_err  = 0;
    endtask

    task automatic model_step(input logic rr, input logic sv, input logic rv,
                              input logic [1:0] rc, input logic dr);
        int r;
        int n;
        int sent;
        sent = (m_mode == M_ACTIVE && m_cred > 0 && sv) ? 1 : 0;
        r = 0;
        if (rv) begin
            if (int'(rc) > MAXR) begin
                m_err = 1;
                r = MAXR;
            end else begin
                r = int'(rc);
            end
        end
        if (m_mode == M_INIT) begin
            if (rv) m_err = 1;
            if (rr) begin
                m_mode = M_ACTIVE;
                m_cred = DEPTH;
            end
        end else if (!rr) begin
            m_mode = M_INIT;
            m_cred = 0;
        end else begin
            n = m_cred - sent + r;
            if (n > DEPTH) begin
                m_err = 1;
                n = DEPTH;
            end
            m_cred = n;
            if (m_mode == M_ACTIVE && dr) m_mode = (n == DEPTH) ? M_DRAINED : M_DRAIN;
            else if (m_mode == M_DRAIN && n == DEPTH) m_mode = M_DRAINED;
            else if (m_mode == M_DRAINED && !dr) m_mode = M_ACTIVE;
        end
    endtask

    // Advance one clock; the model sees the inputs that were stable at the edge.
    task automatic cycle();
        @(posedge clk);
        if (!rst) model_reset();
        else model_step(bus.remote_ready, bus.send_valid, bus.ret_valid, bus.ret_cnt,
                        bus.drain_req);
        #1;
    endtask

    task automatic drive(input logic rr, input logic sv, input logic rv, input logic [1:0] rc,
                         input logic dr);
        bus.remote_ready = rr;
        bus.send_valid   = sv;
        bus.ret_valid    = rv;
        bus.ret_cnt      = rc;
        bus.drain_req    = dr;
    endtask

    initial begin
        logic rr, sv, rv, dr;
        logic [1:0] rc;

        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        #1;
        chk_all("reset", 0, 0, 0, 0);
        cycle();
        cycle();
        rst = 1'b1;

        //       rr    sv    rv    rc    dr    cred rdy drn err
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0);
        add_vec(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4, 1, 0, 0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3, 1, 0, 0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2, 1, 0, 0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1, 0, 0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 0, 0, 0, 0);
        add_vec(1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 2, 1, 0, 0);
        add_vec(1'b1, 1'b1, 1'b1, 2'd1, 1'b0, 2, 1, 0, 0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 2, 0, 0, 0);
        add_vec(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 3, 0, 0, 0);
        add_vec(1'b1, 1'b0, 1'b1, 2'd1, 1'b1, 4, 0, 1, 0);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4, 1, 0, 0);
        add_vec(1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 4, 1, 0, 1);
        add_vec(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 4, 1, 0, 1);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3, 1, 0, 1);
        add_vec(1'b1, 1'b0, 1'b1, 2'd3, 1'b0, 4, 1, 0, 1);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b1, 4, 0, 1, 1);
        add_vec(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4, 1, 0, 1);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 3, 1, 0, 1);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 2, 1, 0, 1);
        add_vec(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1, 1, 0, 1);

        foreach (vecs[i]) begin
            drive(vecs[i].rr, vecs[i].sv, vecs[i].rv, vecs[i].rc, vecs[i].dr);
            cycle();
            chk_all($sformatf("vec%0d", i), vecs[i].ec, vecs[i].esr, vecs[i].edr, vecs[i].eerr);
        end

        // Async reset mid-burst, away from any clock edge.
        drive(1'b1, 1'b1, 1'b0, 2'd0, 1'b0);
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        bus.send_valid = 1'b0;
        cycle();
        chk_all("rst_hold", 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        chk_all("reinit", 4, 1, 0, 0);

        // Randomised traffic against the reference model.
        dr = 1'b0;
        for (int n = 0; n < 600; n++) begin
            if (m_mode == M_INIT) rr = ($urandom_range(0, 3) != 0);
            else rr = ($urandom_range(0, 39) != 0);
            sv = 1'($urandom_range(0, 1));
            rv = (m_mode != M_INIT) && ($urandom_range(0, 2) == 0);
            rc = 2'($urandom_range(0, 3));
            if (!dr && m_mode == M_ACTIVE && $urandom_range(0, 15) == 0) dr = 1'b1;
            else if (dr && m_mode == M_DRAINED && $urandom_range(0, 3) == 0) dr = 1'b0;
            drive(rr, sv, rv, rc, dr);
            cycle();
            chk_all($sformatf("rand%0d", n), m_cred,
                    (m_mode == M_ACTIVE && m_cred != 0) ? 1 : 0,
                    (m_mode == M_DRAINED) ? 1 : 0, m_err);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
